pipe_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage CPU.
- Collects stall requests from the IF, ID, EX and MEM stages and drives a 6-bit stall vector to the PC register and the if_id, id_ex, ex_mem and mem_wb pipeline registers.
- Sequences exception flushes: it asserts flush to every pipeline register and redirects the PC to the exception target.
- Keeps a saturating stall-cycle performance counter and a sticky watchdog flag for stalls that never end.

---
 rtl/pipe_ctrl_if.sv | 50 +++++
 rtl/pipe_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central sequencer.
// The master modport is the stage side; the slave modport is pipe_ctrl.
interface pipe_ctrl_if #(
   parameter int unsigned PC_W = 32
) ();

   logic            stallreq_if;
   logic            stallreq_id;
   logic            stallreq_ex;
   logic            stallreq_mem;
   logic            except_req;
   logic [PC_W-1:0] except_pc;
   logic            cnt_clr;
   logic [5:0]      stall;
   logic            flush;
   logic [PC_W-1:0] new_pc;
   logic [31:0]     stall_cnt;
   logic            stall_timeout;

   modport master (
      output stallreq_if,
      output stallreq_id,
      output stallreq_ex,
      output stallreq_mem,
      output except_req,
      output except_pc,
      output cnt_clr,
      input  stall,
      input  flush,
      input  new_pc,
      input  stall_cnt,
      input  stall_timeout
   );

   modport slave (
      input  stallreq_if,
      input  stallreq_id,
      input  stallreq_ex,
      input  stallreq_mem,
      input  except_req,
      input  except_pc,
      input  cnt_clr,
      output stall,
      output flush,
      output new_pc,
      output stall_cnt,
      output stall_timeout
   );

endinterface

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline sequencer: stall vector generation, exception flush
// sequencing, saturating stall-cycle counter and sticky stall watchdog.
module pipe_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned TIMEOUT      = 1024,
   parameter int unsigned PC_W         = 32
) (
   input logic        clk,
   input logic        rst,
   pipe_ctrl_if.slave bus
);

   localparam int unsigned RunW = $clog2(TIMEOUT + 1);
   localparam logic [RunW-1:0] RunMax = RunW'(TIMEOUT);
   localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

   typedef enum logic [0:0] {StIdle, StFlush} state_e;

   state_e          state_q, state_d;
   logic [3:0]      fcnt_q, fcnt_d;
   logic            flush_q, flush_d;
   logic [PC_W-1:0] new_pc_q, new_pc_d;
   logic [31:0]     cnt_q, cnt_d;
   logic [RunW-1:0] run_q, run_d;
   logic            tmo_q, tmo_d;
   logic [5:0]      stall;
   logic            accept;

   // Requests are masked while flushing and during the reset cycle.
   always_comb begin
      stall = 6'b000000;
      if (rst && (state_q == StIdle)) begin
         if (bus.stallreq_mem) begin
            stall = 6'b011111;
         end else if (bus.stallreq_ex) begin
            stall = 6'b001111;
         end else if (bus.stallreq_id) begin
            stall = 6'b000111;
         end else if (bus.stallreq_if) begin
            stall = 6'b000011;
         end
      end
   end

   // A MEM stall defers the exception; inside FLUSH a newer exception always wins.
   assign accept = bus.except_req &&
                   (((state_q == StIdle) && !bus.stallreq_mem) || (state_q == StFlush));

   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      flush_d  = 1'b0;
      new_pc_d = new_pc_q;
      if (accept) begin
         state_d  = StFlush;
         fcnt_d   = FlushLoad;
         flush_d  = 1'b1;
         new_pc_d = bus.except_pc;
      end else if (state_q == StFlush) begin
         if (fcnt_q == 4'd0) begin
            state_d = StIdle;
         end else begin
            fcnt_d  = fcnt_q - 4'd1;
            flush_d = 1'b1;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (bus.cnt_clr) begin
         cnt_d = 32'd0;
      end else if (stall[0] && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // Watchdog flags as soon as the run counter lands on TIMEOUT.
   always_comb begin
      run_d = run_q;
      if (!stall[0]) begin
         run_d = '0;
      end else if (run_q != RunMax) begin
         run_d = run_q + 1'b1;
      end
      tmo_d = tmo_q | (run_d == RunMax);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         fcnt_q   <= 4'd0;
         flush_q  <= 1'b0;
         new_pc_q <= '0;
         cnt_q    <= 32'd0;
         run_q    <= '0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         fcnt_q   <= fcnt_d;
         flush_q  <= flush_d;
         new_pc_q <= new_pc_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
         tmo_q    <= tmo_d;
      end
   end

   assign bus.stall         = stall;
   assign bus.flush         = flush_q;
   assign bus.new_pc        = new_pc_q;
   assign bus.stall_cnt     = cnt_q;
   assign bus.stall_timeout = tmo_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: one instance with single-cycle flush,
// one with three-cycle flush, both with an 8-cycle watchdog.
module tb_pipe_ctrl;

   logic clk;
   logic rst;

   pipe_ctrl_if #(.PC_W(32)) bus_f1 ();
   pipe_ctrl_if #(.PC_W(32)) bus_f3 ();

   pipe_ctrl #(.FLUSH_CYCLES(1), .TIMEOUT(8), .PC_W(32)) u_f1 (
      .clk (clk),
      .rst (rst),
      .bus (bus_f1)
   );

   pipe_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(8), .PC_W(32)) u_f3 (
      .clk (clk),
      .rst (rst),
      .bus (bus_f3)
   );

   typedef struct {
      string       tag;
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
      logic [31:0] cnt;
      logic        tmo;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus_f1.stallreq_if = 1'b0; bus_f1.stallreq_id = 1'b0;
      bus_f1.stallreq_ex = 1'b0; bus_f1.stallreq_mem = 1'b0;
      bus_f1.except_req = 1'b0; bus_f1.except_pc = 32'd0; bus_f1.cnt_clr = 1'b0;
      bus_f3.stallreq_if = 1'b0; bus_f3.stallreq_id = 1'b0;
      bus_f3.stallreq_ex = 1'b0; bus_f3.stallreq_mem = 1'b0;
      bus_f3.except_req = 1'b0; bus_f3.except_pc = 32'd0; bus_f3.cnt_clr = 1'b0;
   endtask

   // req = {mem, ex, id, if}; one clock per call, checked mid-low before the edge.
   task automatic step(input bit sel, input logic [3:0] req, input logic exc,
                       input logic [31:0] pc, input logic clr, input logic [5:0] e_stall,
                       input logic e_flush, input logic [31:0] e_pc, input logic [31:0] e_cnt,
                       input logic e_tmo, input string tag);
      exp_t        e;
      exp_t        o;
      logic [5:0]  s;
      logic        f;
      logic [31:0] p;
      logic [31:0] c;
      logic        t;
      clear_inputs();
      if (sel) begin
         bus_f3.stallreq_mem = req[3]; bus_f3.stallreq_ex = req[2];
         bus_f3.stallreq_id = req[1]; bus_f3.stallreq_if = req[0];
         bus_f3.except_req = exc; bus_f3.except_pc = pc; bus_f3.cnt_clr = clr;
      end else begin
         bus_f1.stallreq_mem = req[3]; bus_f1.stallreq_ex = req[2];
         bus_f1.stallreq_id = req[1]; bus_f1.stallreq_if = req[0];
         bus_f1.except_req = exc; bus_f1.except_pc = pc; bus_f1.cnt_clr = clr;
      end
      e.tag = tag; e.stall = e_stall; e.flush = e_flush;
      e.pc = e_pc; e.cnt = e_cnt; e.tmo = e_tmo;
      sb_q.push_back(e);
      #2;
      if (sel) begin
         s = bus_f3.stall; f = bus_f3.flush; p = bus_f3.new_pc;
         c = bus_f3.stall_cnt; t = bus_f3.stall_timeout;
      end else begin
         s = bus_f1.stall; f = bus_f1.flush; p = bus_f1.new_pc;
         c = bus_f1.stall_cnt; t = bus_f1.stall_timeout;
      end
      o = sb_q.pop_front();
      chk({o.tag, ".stall"}, {26'd0, s}, {26'd0, o.stall});
      chk({o.tag, ".flush"}, {31'd0, f}, {31'd0, o.flush});
      chk({o.tag, ".new_pc"}, p, o.pc);
      chk({o.tag, ".stall_cnt"}, c, o.cnt);
      chk({o.tag, ".timeout"}, {31'd0, t}, {31'd0, o.tmo});
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      step(0, 4'b1111, 1, 32'hdead, 0, 6'b000000, 0, 32'h0, 0, 0, "rst_hold");
      rst = 1'b1;

      step(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 32'h0, 0, 0, "idle0");
      step(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 32'h0, 0, 0, "idle1");
      step(0, 4'b0010, 0, 0, 0, 6'b000111, 0, 32'h0, 0, 0, "id_only");
      step(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 32'h0, 1, 0, "id_cnt");
      step(0, 4'b0111, 0, 0, 0, 6'b001111, 0, 32'h0, 1, 0, "if_id_ex");
      step(0, 4'b1111, 0, 0, 0, 6'b011111, 0, 32'h0, 2, 0, "all_four");

      step(0, 4'b0000, 1, 32'h20, 0, 6'b000000, 0, 32'h0, 3, 0, "exc_accept");
      step(0, 4'b0100, 0, 0, 0, 6'b000000, 1, 32'h20, 3, 0, "flush_pulse");
      step(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 32'h20, 3, 0, "flush_drop");

      step(0, 4'b1000, 1, 32'h40, 0, 6'b011111, 0, 32'h20, 3, 0, "defer1");
      step(0, 4'b1000, 1, 32'h40, 0, 6'b011111, 0, 32'h20, 4, 0, "defer2");
      step(0, 4'b1000, 1, 32'h40, 0, 6'b011111, 0, 32'h20, 5, 0, "defer3");
      step(0, 4'b0000, 1, 32'h40, 0, 6'b000000, 0, 32'h20, 6, 0, "defer_accept");
      step(0, 4'b0000, 0, 0, 0, 6'b000000, 1, 32'h40, 6, 0, "defer_flush");
      step(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 32'h40, 6, 0, "defer_drop");

      for (int i = 0; i < 8; i++) begin
         step(0, 4'b0100, 0, 0, 0, 6'b001111, 0, 32'h40, 32'(6 + i), 0, "wd_run");
      end
      step(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 32'h40, 14, 1, "wd_fire");
      step(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 32'h40, 14, 1, "wd_sticky");

      rst = 1'b0;
      step(0, 4'b1111, 1, 32'hdead, 0, 6'b000000, 0, 32'h40, 14, 1, "rst_cycle");
      rst = 1'b1;
      step(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 32'h0, 0, 0, "post_rst");

      for (int i = 0; i < 8; i++) begin
         step(0, 4'b0100, 0, 0, (i == 4), 6'b001111, 0, 32'h0,
              (i <= 4) ? 32'(i) : 32'(i - 5), 0, "clr_run");
      end
      step(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 32'h0, 3, 1, "clr_fire");

      step(1, 4'b0000, 1, 32'h100, 0, 6'b000000, 0, 32'h0, 0, 0, "f3_accept");
      step(1, 4'b0010, 1, 32'h200, 0, 6'b000000, 1, 32'h100, 0, 0, "f3_reaccept");
      step(1, 4'b0000, 0, 0, 0, 6'b000000, 1, 32'h200, 0, 0, "f3_hold1");
      step(1, 4'b0000, 0, 0, 0, 6'b000000, 1, 32'h200, 0, 0, "f3_hold2");
      step(1, 4'b0000, 0, 0, 0, 6'b000000, 1, 32'h200, 0, 0, "f3_hold3");
      step(1, 4'b0000, 0, 0, 0, 6'b000000, 0, 32'h200, 0, 0, "f3_drop");

      step(1, 4'b0000, 1, 32'h300, 0, 6'b000000, 0, 32'h200, 0, 0, "f3_exc3");
      step(1, 4'b0000, 0, 0, 0, 6'b000000, 1, 32'h300, 0, 0, "f3_flush3");
      rst = 1'b0;
      step(1, 4'b0001, 0, 0, 0, 6'b000000, 1, 32'h300, 0, 0, "f3_rst");
      rst = 1'b1;
      step(1, 4'b0000, 0, 0, 0, 6'b000000, 0, 32'h0, 0, 0, "f3_post_rst");
      step(1, 4'b0000, 0, 0, 0, 6'b000000, 0, 32'h0, 0, 0, "f3_no_redirect");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
